// File: rtl/redraw_scheduler.sv
// Redraw scheduler: tracks dirty grid cells and sequences one border draw and
// one content draw per dirty cell into the drawBox renderer, handshaking on
// its busy flag.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | nothing to draw; leave as soon as any cell is dirty
//   SCAN    | test one cell per cycle in raster order, latch the first dirty one
//   ISSUE_B | wait for renderer idle, then pulse d_cursor
//   WAIT_B  | wait for busy to rise (bounded), then for busy to fall
//   ISSUE_C | wait for renderer idle, then pulse d_reveal
//   WAIT_C  | as WAIT_B; on completion step to the next cell and rescan
module redraw_scheduler #(
    parameter int GRID_SIZE  = 3,
    parameter int GRID_BIT   = 4,
    parameter int STATE_SIZE = 4,
    parameter int CELL_PITCH = 9,
    parameter int START_TMO  = 4
) (
    input  logic                                     clock,
    input  logic                                     resetn,
    input  logic                                     full_redraw,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]           cursorGrid,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]           revealGrid,
    input  logic [STATE_SIZE*GRID_SIZE*GRID_SIZE-1:0] states,
    input  logic                                     box_busy,
    output logic [7:0]                               box_px,
    output logic [6:0]                               box_py,
    output logic                                     cursor_bit,
    output logic                                     reveal_bit,
    output logic [STATE_SIZE-1:0]                    state,
    output logic                                     d_cursor,
    output logic                                     d_reveal,
    output logic                                     idle
);

    localparam int N  = GRID_SIZE * GRID_SIZE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (START_TMO > 1) ? $clog2(START_TMO + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE_B,
        S_WAIT_B,
        S_ISSUE_C,
        S_WAIT_C
    } fsm_t;

    fsm_t                  fsm_q, fsm_d;
    logic [N-1:0]          dirty_q, dirty_d;
    logic [N-1:0]          shadow_c_q, shadow_c_d;
    logic [N-1:0]          shadow_r_q, shadow_r_d;
    logic [GRID_BIT-1:0]   cx_q, cx_d;
    logic [GRID_BIT-1:0]   cy_q, cy_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  seen_q, seen_d;
    logic [7:0]            px_q, px_d;
    logic [6:0]            py_q, py_d;
    logic                  cbit_q, cbit_d;
    logic                  rbit_q, rbit_d;
    logic [STATE_SIZE-1:0] st_q, st_d;
    logic                  d_cursor_q, d_cursor_d;
    logic                  d_reveal_q, d_reveal_d;

    logic [KW-1:0]         k_idx;
    logic [N-1:0]          set_mask;
    logic [N-1:0]          clr_mask;
    logic [GRID_BIT-1:0]   cx_next, cy_next;
    logic                  wait_done;

    // Cell index of (cx,cy) and raster successor with wrap at the last cell.
    always_comb begin
        k_idx = KW'((GRID_SIZE - 1 - int'(cx_q)) + (GRID_SIZE - 1 - int'(cy_q)) * GRID_SIZE);
        cx_next = cx_q + GRID_BIT'(1);
        cy_next = cy_q;
        if (cx_q == GRID_BIT'(GRID_SIZE - 1)) begin
            cx_next = '0;
            cy_next = (cy_q == GRID_BIT'(GRID_SIZE - 1)) ? '0 : cy_q + GRID_BIT'(1);
        end
    end

    // Next-state logic: dirty tracking plus the draw sequencer.
    always_comb begin
        fsm_d      = fsm_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        tmo_d      = tmo_q;
        seen_d     = seen_q;
        px_d       = px_q;
        py_d       = py_q;
        cbit_d     = cbit_q;
        rbit_d     = rbit_q;
        st_d       = st_q;
        d_cursor_d = 1'b0;
        d_reveal_d = 1'b0;
        clr_mask   = '0;
        wait_done  = 1'b0;
        shadow_c_d = cursorGrid;
        shadow_r_d = revealGrid;
        set_mask   = (cursorGrid ^ shadow_c_q) | (revealGrid ^ shadow_r_q) | {N{full_redraw}};

        case (fsm_q)
            S_IDLE: begin
                if (dirty_q != '0) fsm_d = S_SCAN;
            end
            S_SCAN: begin
                if (dirty_q == '0) begin
                    fsm_d = S_IDLE;
                end else if (dirty_q[k_idx]) begin
                    clr_mask = N'(1) << k_idx;
                    px_d     = 8'(int'(cx_q) * CELL_PITCH);
                    py_d     = 7'(int'(cy_q) * CELL_PITCH);
                    cbit_d   = cursorGrid[k_idx];
                    rbit_d   = revealGrid[k_idx];
                    st_d     = STATE_SIZE'(states >> (int'(k_idx) * STATE_SIZE));
                    fsm_d    = S_ISSUE_B;
                end else begin
                    cx_d = cx_next;
                    cy_d = cy_next;
                end
            end
            S_ISSUE_B, S_ISSUE_C: begin
                if (!box_busy) begin
                    tmo_d  = TW'(START_TMO - 1);
                    seen_d = 1'b0;
                    if (fsm_q == S_ISSUE_B) begin
                        d_cursor_d = 1'b1;
                        fsm_d      = S_WAIT_B;
                    end else begin
                        d_reveal_d = 1'b1;
                        fsm_d      = S_WAIT_C;
                    end
                end
            end
            S_WAIT_B, S_WAIT_C: begin
                // A renderer that never acknowledges is given up on after START_TMO cycles.
                if (!seen_q) begin
                    if (box_busy)            seen_d    = 1'b1;
                    else if (tmo_q == '0)    wait_done = 1'b1;
                    else                     tmo_d     = tmo_q - TW'(1);
                end else if (!box_busy) begin
                    wait_done = 1'b1;
                end
                if (wait_done) begin
                    if (fsm_q == S_WAIT_B) begin
                        fsm_d = S_ISSUE_C;
                    end else begin
                        cx_d  = cx_next;
                        cy_d  = cy_next;
                        fsm_d = S_SCAN;
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase

        // A new change on a bit wins over the scan clearing it this cycle.
        dirty_d = (dirty_q & ~clr_mask) | set_mask;
    end

    // State and output registers; reset leaves every cell dirty so the board redraws.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fsm_q      <= S_IDLE;
            dirty_q    <= '1;
            shadow_c_q <= '0;
            shadow_r_q <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            tmo_q      <= '0;
            seen_q     <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            cbit_q     <= 1'b0;
            rbit_q     <= 1'b0;
            st_q       <= '0;
            d_cursor_q <= 1'b0;
            d_reveal_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            dirty_q    <= dirty_d;
            shadow_c_q <= shadow_c_d;
            shadow_r_q <= shadow_r_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            tmo_q      <= tmo_d;
            seen_q     <= seen_d;
            px_q       <= px_d;
            py_q       <= py_d;
            cbit_q     <= cbit_d;
            rbit_q     <= rbit_d;
            st_q       <= st_d;
            d_cursor_q <= d_cursor_d;
            d_reveal_q <= d_reveal_d;
        end
    end

    assign box_px     = px_q;
    assign box_py     = py_q;
    assign cursor_bit = cbit_q;
    assign reveal_bit = rbit_q;
    assign state      = st_q;
    assign d_cursor   = d_cursor_q;
    assign d_reveal   = d_reveal_q;
    assign idle       = (fsm_q == S_IDLE) && (dirty_q == '0);

endmodule

// File: tb/tb_redraw_scheduler.sv
// Bench for redraw_scheduler: a behavioural renderer answers each request, and a
// set-of-dirty-cells model predicts which cell (and with which fields) must be
// drawn next, taking the first dirty cell at or after the scan pointer.
module tb_redraw_scheduler;

    localparam int G     = 3;
    localparam int N     = G * G;
    localparam int SS    = 4;
    localparam int PITCH = 9;
    localparam int SW    = SS * N;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          full_redraw = 1'b0;
    logic [N-1:0]  cursorGrid = '0;
    logic [N-1:0]  revealGrid = '0;
    logic [SW-1:0] states = '0;
    logic          box_busy = 1'b0;
    logic [7:0]    box_px;
    logic [6:0]    box_py;
    logic          cursor_bit;
    logic          reveal_bit;
    logic [SS-1:0] state;
    logic          d_cursor;
    logic          d_reveal;
    logic          idle;

    redraw_scheduler #(
        .GRID_SIZE(G), .GRID_BIT(4), .STATE_SIZE(SS), .CELL_PITCH(PITCH), .START_TMO(4)
    ) dut (
        .clock(clock), .resetn(resetn), .full_redraw(full_redraw),
        .cursorGrid(cursorGrid), .revealGrid(revealGrid), .states(states),
        .box_busy(box_busy), .box_px(box_px), .box_py(box_py),
        .cursor_bit(cursor_bit), .reveal_bit(reveal_bit), .state(state),
        .d_cursor(d_cursor), .d_reveal(d_reveal), .idle(idle)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model state: dirty flags indexed by raster position r = cy*G + cx.
    bit m_dirty[N];
    int m_ptr = 0;
    int m_cur = 0;
    int exp_px, exp_py, exp_st;
    bit expect_border = 1'b1;

    // Renderer / monitor controls.
    bit rend_dead = 1'b0;
    int busy_fixed = 20;
    int rend_cnt = 0;
    int arm_mode = 0;
    int mid_left = 0;
    bit s3_done = 1'b0;
    bit check_gap = 1'b0;
    int n_border = 0, n_content = 0, cyc = 0, t_border = 0;
    int k0_draws = 0, k0_rbit = 0, k0_state = 0;

    function automatic int raster_of_k(input int k);
        return (G - 1 - k / G) * G + (G - 1 - k % G);
    endfunction

    function automatic int k_of_raster(input int r);
        return (G - 1 - r % G) + (G - 1 - r / G) * G;
    endfunction

    function automatic int model_pending();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_dirty[i]);
        return c;
    endfunction

    function automatic logic [SW-1:0] rand_states();
        logic [SW-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k*SS +: SS] = SS'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic model_all_dirty();
        for (int i = 0; i < N; i++) m_dirty[i] = 1'b1;
    endtask

    // Drive new grid inputs and mark every cell whose cursor or reveal flag changed.
    task automatic drive_inputs(input logic [N-1:0] c, input logic [N-1:0] r, input logic [SW-1:0] s);
        for (int k = 0; k < N; k++)
            if (c[k] !== cursorGrid[k] || r[k] !== revealGrid[k]) m_dirty[raster_of_k(k)] = 1'b1;
        cursorGrid = c;
        revealGrid = r;
        states     = s;
    endtask

    task automatic on_border();
        int e = -1;
        int k;
        chk("alt_border", expect_border, 1);
        expect_border = 1'b0;
        for (int i = 0; i < N; i++) begin
            int r = (m_ptr + i) % N;
            if (e < 0 && m_dirty[r]) e = r;
        end
        chk("border_expected", (e >= 0), 1);
        if (e >= 0) begin
            k      = k_of_raster(e);
            exp_px = (e % G) * PITCH;
            exp_py = (e / G) * PITCH;
            exp_st = int'(states[k*SS +: SS]);
            chk("b_px", box_px, exp_px);
            chk("b_py", box_py, exp_py);
            chk("b_cursor", cursor_bit, cursorGrid[k]);
            chk("b_reveal", reveal_bit, revealGrid[k]);
            chk("b_state", state, exp_st);
            m_dirty[e] = 1'b0;
            m_cur      = e;
            if (k == 0) begin
                k0_draws++;
                k0_rbit  = int'(reveal_bit);
                k0_state = int'(state);
            end
            if (arm_mode == 1 && k == 0 && !s3_done) begin
                logic [SW-1:0] s = states;
                s[SS-1:0] = SS'(9);
                drive_inputs(cursorGrid, revealGrid | N'(1), s);
                s3_done = 1'b1;
            end else if (arm_mode == 2 && mid_left > 0 && $urandom_range(0, 2) == 0) begin
                logic [SW-1:0] s = states;
                int kc = $urandom_range(0, N - 1);
                int kr = $urandom_range(0, N - 1);
                int ks = $urandom_range(0, N - 1);
                s[ks*SS +: SS] = SS'($urandom_range(0, 9));
                drive_inputs(N'(1) << kc, revealGrid | (N'(1) << kr), s);
                mid_left--;
            end
        end
        t_border = cyc;
        n_border++;
    endtask

    task automatic on_content();
        chk("alt_content", expect_border, 0);
        expect_border = 1'b1;
        chk("c_px", box_px, exp_px);
        chk("c_py", box_py, exp_py);
        chk("c_state", state, exp_st);
        if (check_gap) chk("tmo_gap", cyc - t_border, 5);
        m_ptr = (m_cur + 1) % N;
        n_content++;
    endtask

    // Monitor and behavioural renderer, sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (!resetn) begin
                rend_cnt = 0;
                box_busy = 1'b0;
            end else begin
                if (d_cursor || d_reveal) begin
                    chk("one_pulse", d_cursor & d_reveal, 0);
                    chk("outstanding", (rend_cnt != 0), 0);
                end
                if (d_cursor) on_border();
                if (d_reveal) on_content();
                if (rend_dead) begin
                    rend_cnt = 0;
                end else if (d_cursor || d_reveal) begin
                    rend_cnt = (busy_fixed > 0) ? busy_fixed : int'($urandom_range(1, 20));
                end else if (rend_cnt > 0) begin
                    rend_cnt--;
                end
                box_busy = (rend_cnt > 0);
            end
        end
    end

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(posedge clock);
            #2;
            if (idle) break;
        end
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_undrawn"}, model_pending(), 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_px"}, box_px, 0);
        chk({tag, "_py"}, box_py, 0);
        chk({tag, "_cbit"}, cursor_bit, 0);
        chk({tag, "_rbit"}, reveal_bit, 0);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_dcur"}, d_cursor, 0);
        chk({tag, "_drev"}, d_reveal, 0);
        chk({tag, "_idle"}, idle, 0);
    endtask

    task automatic pulse_full(input logic [N-1:0] c);
        full_redraw = 1'b1;
        drive_inputs(c, revealGrid, states);
        model_all_dirty();
        @(posedge clock);
        #2;
        full_redraw = 1'b0;
    endtask

    initial begin
        int base;
        int i;
        states = rand_states();
        model_all_dirty();
        repeat (3) @(posedge clock);
        #2;
        chk_reset_outs("rst");

        // Board drawn once after reset release, fixed 20-cycle renderer.
        resetn = 1'b1;
        base = n_border + n_content;
        wait_idle("s1");
        chk("s1_pulses", n_border + n_content - base, 18);

        // Cursor appears at k=8, then moves to k=4.
        base = n_border;
        drive_inputs(N'(1) << 8, revealGrid, states);
        wait_idle("s2a");
        chk("s2a_draws", n_border - base, 1);
        base = n_border;
        drive_inputs(N'(1) << 4, revealGrid, states);
        wait_idle("s2b");
        chk("s2b_draws", n_border - base, 2);

        // Reveal of cell k=0 while it is being drawn forces a second draw.
        arm_mode = 1;
        k0_draws = 0;
        busy_fixed = 0;
        drive_inputs(N'(1) << 0, revealGrid, states);
        wait_idle("s3");
        arm_mode = 0;
        chk("s3_k0_draws", k0_draws, 2);
        chk("s3_k0_reveal", k0_rbit, 1);
        chk("s3_k0_state", k0_state, 9);

        // Renderer never answers: every request times out, scan still completes.
        rend_dead = 1'b1;
        check_gap = 1'b1;
        base = n_border + n_content;
        pulse_full(cursorGrid);
        wait_idle("s4");
        chk("s4_pulses", n_border + n_content - base, 18);
        rend_dead = 1'b0;
        check_gap = 1'b0;

        // Reset while waiting on a content draw, then full redraw from (0,0).
        busy_fixed = 20;
        base = n_content;
        pulse_full(cursorGrid);
        for (i = 0; i < 3000 && n_content < base + 3; i++) begin
            @(posedge clock);
            #2;
        end
        chk("s5_reached_wait_c", (n_content >= base + 3), 1);
        @(posedge clock);
        #3;
        resetn = 1'b0;
        model_all_dirty();
        m_ptr = 0;
        expect_border = 1'b1;
        #1;
        chk_reset_outs("s5rst");
        repeat (2) @(posedge clock);
        #2;
        base = n_border + n_content;
        resetn = 1'b1;
        wait_idle("s5");
        chk("s5_pulses", n_border + n_content - base, 18);

        // Full redraw together with a cursor move: each cell exactly once.
        busy_fixed = 0;
        base = n_border;
        pulse_full(N'(1) << 5);
        wait_idle("s6");
        chk("s6_draws", n_border - base, 9);

        // Random rounds with mid-draw disturbances.
        arm_mode = 2;
        for (int round = 0; round < 8; round++) begin
            logic [N-1:0] c;
            c = ($urandom_range(0, 3) == 0) ? '0 : N'(1) << $urandom_range(0, N - 1);
            mid_left = 3;
            if ($urandom_range(0, 3) == 0) begin
                pulse_full(c);
            end else begin
                drive_inputs(c, revealGrid | N'($urandom_range(0, (1 << N) - 1)), rand_states());
            end
            wait_idle("rnd");
        end
        arm_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
